// File: rtl/iterative_shifter_lr.sv
// iterative_shifter_lr: multi-cycle shifter that moves the operand one bit per
// clock (LSL / LSR / ASR, plus ROR when ITERATIVE_SHIFTER_ROTATE_EN is defined).
// Valid/ready on both sides; one transaction in flight, no result/accept bypass.
// Build option: define ITERATIVE_SHIFTER_ROTATE_EN to make op 2'b11 rotate right;
// when undefined op 2'b11 behaves as LSR and no rotate path exists.
module iterative_shifter_lr #(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_amt,
    input  logic [1:0]    up_op,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    // FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Op encoding
    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Largest legal shift amount; larger requests (non-power-of-two N) clamp here
    localparam logic [SW-1:0] AMT_MAX = SW'(N - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_shift;
    logic [SW-1:0] r_cnt;
    logic [1:0]    r_op;
    logic          r_up_ready;
    logic          r_down_valid;

    logic [1:0]    w_next_state;
    logic [N-1:0]  w_next_shift;
    logic [SW-1:0] w_next_cnt;
    logic [1:0]    w_next_op;
    logic [N-1:0]  w_step;
    logic [SW-1:0] w_amt;
    logic          w_accept;
    logic          w_handoff;

    assign w_accept  = up_valid && r_up_ready;
    assign w_handoff = r_down_valid && down_ready;

    // Clamp the requested amount to the legal range
    assign w_amt = (up_amt > AMT_MAX) ? AMT_MAX : up_amt;

    // One-position step of the shift register for the captured op
    always_comb begin
        w_step = r_shift;
        case (r_op)
            OP_LSL:  w_step = {r_shift[N-2:0], 1'b0};
            OP_LSR:  w_step = {1'b0, r_shift[N-1:1]};
            OP_ASR:  w_step = {r_shift[N-1], r_shift[N-1:1]};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            OP_ROR:  w_step = {r_shift[0], r_shift[N-1:1]};
`else
            OP_ROR:  w_step = {1'b0, r_shift[N-1:1]};
`endif
            default: w_step = r_shift;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        w_next_state = r_state;
        w_next_shift = r_shift;
        w_next_cnt   = r_cnt;
        w_next_op    = r_op;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_shift = up_data;
                    w_next_cnt   = w_amt;
                    w_next_op    = up_op;
                    w_next_state = (w_amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_next_shift = w_step;
                w_next_cnt   = r_cnt - SW'(1);
                if (r_cnt <= SW'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (w_handoff) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_op         <= OP_LSL;
            r_up_ready   <= 1'b1;
            r_down_valid <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_shift      <= w_next_shift;
            r_cnt        <= w_next_cnt;
            r_op         <= w_next_op;
            r_up_ready   <= (w_next_state == S_IDLE);
            r_down_valid <= (w_next_state == S_DONE);
        end
    end

    // Result is the shift register in every state; consumers qualify with down_valid
    assign up_ready   = r_up_ready;
    assign down_valid = r_down_valid;
    assign down_data  = r_shift;

endmodule

// File: tb/tb_iterative_shifter_lr.sv
// Scoreboard bench for iterative_shifter_lr (N=8): the driver pushes the
// hand-computed result and first-valid cycle; a monitor pops and compares.
module tb_iterative_shifter_lr;

    localparam int unsigned N  = 8;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_amt;
    logic [1:0]    up_op;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;

    typedef struct {
        logic [N-1:0] data;
        int           vld_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   seen = 1'b0;
    bit   chk_after = 1'b0;

    iterative_shifter_lr #(.N(N), .SW(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amt     (up_amt),
        .up_op      (up_op),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Issue one request; called and returns at a falling edge
    task automatic send(input logic [N-1:0] d, input logic [SW-1:0] amt,
                        input logic [1:0] op, input logic [N-1:0] exp, input bit push);
        int n = 0;
        up_data  = d;
        up_amt   = amt;
        up_op    = op;
        up_valid = 1'b1;
        while (!up_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!up_ready) begin
            fail_now("accept_timeout");
            up_valid = 1'b0;
            return;
        end
        check("no_bypass", down_valid, 0);
        if (push) sb_q.push_back('{exp, cyc + 1 + int'(amt)});
        @(negedge clk);
        up_valid = 1'b0;
        up_data  = ~d;
        up_amt   = ~amt;
        up_op    = ~op;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            fail_now("drain_timeout");
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compare each presented result against the scoreboard head
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            seen      = 1'b0;
            chk_after = 1'b0;
        end else begin
            if (chk_after) begin
                check("up_ready_after_handoff", up_ready, 1);
                check("down_valid_after_handoff", down_valid, 0);
                chk_after = 1'b0;
            end
            if (down_valid) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    if (!seen) begin
                        check("latency_cycle", cyc, sb_q[0].vld_cyc);
                        seen = 1'b1;
                    end
                    check("down_data", down_data, sb_q[0].data);
                    check("up_ready_busy", up_ready, 0);
                    if (down_ready) begin
                        void'(sb_q.pop_front());
                        seen      = 1'b0;
                        chk_after = 1'b1;
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        up_valid   = 1'b1;
        up_data    = 8'h3C;
        up_amt     = 3'd2;
        up_op      = 2'b00;
        down_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_up_ready", up_ready, 1);
        check("rst_down_valid", down_valid, 0);
        check("rst_down_data", down_data, 0);
        up_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("idle_down_valid", down_valid, 0);

        // Basic ops
        send(8'h1D, 3'd3, 2'b00, 8'hE8, 1'b1);
        send(8'hB4, 3'd3, 2'b01, 8'h16, 1'b1);
        send(8'hB4, 3'd3, 2'b10, 8'hF6, 1'b1);
        send(8'h34, 3'd2, 2'b10, 8'h0D, 1'b1);
        send(8'hA5, 3'd0, 2'b00, 8'hA5, 1'b1);
        send(8'h80, 3'd7, 2'b01, 8'h01, 1'b1);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
        send(8'h81, 3'd1, 2'b11, 8'hC0, 1'b1);
        send(8'h81, 3'd7, 2'b11, 8'h03, 1'b1);
`else
        send(8'h81, 3'd1, 2'b11, 8'h40, 1'b1);
        send(8'h81, 3'd7, 2'b11, 8'h01, 1'b1);
`endif
        send(8'h96, 3'd7, 2'b10, 8'hFF, 1'b1);
        drain();

        // Backpressure: result held 5 cycles, second request waits for handoff
        down_ready = 1'b0;
        send(8'h01, 3'd1, 2'b00, 8'h02, 1'b1);
        fork
            begin
                repeat (6) @(negedge clk);
                down_ready = 1'b1;
            end
            send(8'h55, 3'd2, 2'b01, 8'h15, 1'b1);
        join
        drain();

        // Reset in the middle of a shift: nothing may come out
        send(8'hFF, 3'd5, 2'b00, 8'hE0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_down_valid", down_valid, 0);
        check("midrst_down_data", down_data, 0);
        check("midrst_up_ready", up_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", down_valid, 0);
        send(8'h0F, 3'd4, 2'b00, 8'hF0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
